// File: rtl/waveform_pkg.sv
// Shared types and default parameters for the waveform analyzer.
package waveform_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_CNT_W  = 20;
    localparam int DEFAULT_HYST   = 256;

endpackage

// File: rtl/minmax_tracker.sv
// Running signed min/max register pair; a seed overrides any update on the same edge.
module minmax_tracker
    import waveform_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     seed,
    input  logic signed [DATA_W-1:0] seed_val,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] max,
    output logic signed [DATA_W-1:0] min
);

    always_ff @(posedge clk) begin
        if (seed) begin
            max <= seed_val;
            min <= seed_val;
        end else if (update) begin
            if (din > max) max <= din;
            if (din < min) min <= din;
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// Locks onto hysteresis-qualified rising zero crossings and reports period, min, max
// and peak-to-peak amplitude for every full cycle of the input waveform.
//
//   state   | meaning
//   IDLE    | not locked; waiting for a low sample followed by a high sample
//   MEASURE | locked; counting samples and tracking min/max until the next crossing
module waveform_analyzer
    import waveform_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int HYST   = DEFAULT_HYST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     meas_valid,
    output logic [CNT_W-1:0]         period_out,
    output logic signed [DATA_W-1:0] max_out,
    output logic signed [DATA_W-1:0] min_out,
    output logic [DATA_W:0]          amp_out,
    output logic                     locked,
    output logic                     timeout
);

    localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);
    // Last count value that still allows a crossing to report period 2^CNT_W-1.
    localparam logic [CNT_W-1:0]         CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t                     state;
    state_t                     state_nxt;
    logic                       armed;
    logic [CNT_W-1:0]           cnt;
    logic                       is_low;
    logic                       is_high;
    logic                       qual;
    logic                       meas_hit;
    logic                       expire;
    logic                       trk_update;
    logic signed [DATA_W-1:0]   run_max;
    logic signed [DATA_W-1:0]   run_min;

    assign is_low  = (sample_in <= HYST_NEG);
    assign is_high = (sample_in >= HYST_POS);
    assign qual    = sample_valid && is_high && armed;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (qual) state_nxt = MEASURE;
            MEASURE: if (sample_valid && !qual && (cnt == CNT_LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        meas_hit   = 1'b0;
        expire     = 1'b0;
        trk_update = 1'b0;
        locked     = (state == MEASURE);
        if ((state == MEASURE) && sample_valid) begin
            if (qual) begin
                meas_hit = 1'b1;
            end else begin
                trk_update = 1'b1;
                expire     = (cnt == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed      <= 1'b0;
            cnt        <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period_out <= '0;
            max_out    <= '0;
            min_out    <= '0;
            amp_out    <= '0;
        end else begin
            meas_valid <= meas_hit;
            timeout    <= expire;
            if (sample_valid) begin
                if (qual || expire) begin
                    armed <= 1'b0;
                    cnt   <= '0;
                end else begin
                    if (is_low) armed <= 1'b1;
                    if (state == MEASURE) cnt <= cnt + 1'b1;
                end
            end
            if (meas_hit) begin
                period_out <= cnt + 1'b1;
                max_out    <= run_max;
                min_out    <= run_min;
                // Sign-extend both operands so the full signed range never wraps.
                amp_out    <= $unsigned({run_max[DATA_W-1], run_max} - {run_min[DATA_W-1], run_min});
            end
        end
    end

    minmax_tracker #(.DATA_W(DATA_W)) u_tracker (
        .clk      (clk),
        .seed     (qual),
        .seed_val (sample_in),
        .update   (trk_update),
        .din      (sample_in),
        .max      (run_max),
        .min      (run_min)
    );

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench for waveform_analyzer: default instance plus a CNT_W=4 instance for timeout checks.
module tb_waveform_analyzer;

    typedef struct {
        int cyc;
        int period;
        int mx;
        int mn;
        int amp;
    } exp_t;

    logic               clk;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;

    logic               meas_valid, locked, timeout;
    logic [19:0]        period_out;
    logic signed [15:0] max_out, min_out;
    logic [16:0]        amp_out;

    logic               meas_valid_t, locked_t, timeout_t;
    logic [3:0]         period_out_t;
    logic signed [15:0] max_out_t, min_out_t;
    logic [16:0]        amp_out_t;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    bit   chk_t = 1'b0;
    exp_t q[$];
    exp_t q_t[$];

    waveform_analyzer dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_valid(meas_valid), .period_out(period_out), .max_out(max_out),
        .min_out(min_out), .amp_out(amp_out), .locked(locked), .timeout(timeout)
    );

    waveform_analyzer #(.CNT_W(4)) dut_t (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_valid(meas_valid_t), .period_out(period_out_t), .max_out(max_out_t),
        .min_out(min_out_t), .amp_out(amp_out_t), .locked(locked_t), .timeout(timeout_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        exp_t e;
        if (meas_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_meas: cycle %0d period %0d, required no pulse", cycle, period_out);
            end else begin
                e = q.pop_front();
                if (cycle != e.cyc || int'(period_out) != e.period || int'(max_out) != e.mx ||
                    int'(min_out) != e.mn || int'(amp_out) != e.amp || timeout !== 1'b0) begin
                    fails++;
                    $display("FAIL meas: got cyc=%0d per=%0d max=%0d min=%0d amp=%0d to=%b, required cyc=%0d per=%0d max=%0d min=%0d amp=%0d to=0",
                             cycle, period_out, max_out, min_out, amp_out, timeout,
                             e.cyc, e.period, e.mx, e.mn, e.amp);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_t && meas_valid_t === 1'b1) begin
            tests++;
            if (q_t.size() == 0) begin
                fails++;
                $display("FAIL unexpected_meas_t: cycle %0d period %0d, required no pulse", cycle, period_out_t);
            end else begin
                e = q_t.pop_front();
                if (cycle != e.cyc || int'(period_out_t) != e.period || int'(max_out_t) != e.mx ||
                    int'(min_out_t) != e.mn || int'(amp_out_t) != e.amp || timeout_t !== 1'b0) begin
                    fails++;
                    $display("FAIL meas_t: got cyc=%0d per=%0d max=%0d min=%0d amp=%0d to=%b, required cyc=%0d per=%0d max=%0d min=%0d amp=%0d to=0",
                             cycle, period_out_t, max_out_t, min_out_t, amp_out_t, timeout_t,
                             e.cyc, e.period, e.mx, e.mn, e.amp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic signed [15:0] v, input logic vld);
        sample_in    = v;
        sample_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input int mx, input int mn, input int amp);
        q.push_back('{cycle, p, mx, mn, amp});
    endtask

    task automatic push_t(input int p, input int mx, input int mn, input int amp);
        q_t.push_back('{cycle, p, mx, mn, amp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(16'sd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        step(16'sd0, 1'b0);
        step(16'sd0, 1'b0);
        tests++;
        if (q.size() != 0 || q_t.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: %0d/%0d measurements outstanding, required 0/0", name, q.size(), q_t.size());
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (meas_valid !== 1'b0 || timeout !== 1'b0 || locked !== 1'b0 || period_out !== '0 ||
            max_out !== '0 || min_out !== '0 || amp_out !== '0) begin
            fails++;
            $display("FAIL %s: mv=%b to=%b lk=%b per=%0d max=%0d min=%0d amp=%0d, required all 0",
                     name, meas_valid, timeout, locked, period_out, max_out, min_out, amp_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(16'sd0, 1'b0);
        step(16'sd0, 1'b0);
        reset = 1'b0;
        check_zero("reset_state");
        tests++;
        if (locked_t !== 1'b0 || timeout_t !== 1'b0 || meas_valid_t !== 1'b0) begin
            fails++;
            $display("FAIL reset_state_t: lk=%b to=%b mv=%b, required 0", locked_t, timeout_t, meas_valid_t);
        end
    endtask

    task automatic test_square(input bit toggle, input string name);
        logic signed [15:0] r;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 8; i++) begin
                step((i < 4) ? -16'sd1000 : 16'sd1000, 1'b1);
                if (i == 4 && c >= 1) push(8, 1000, -1000, 2000);
                if (toggle) begin
                    r = 16'($urandom);
                    step(r, 1'b0);
                end
            end
        end
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL %s_locked: locked=%b, required 1", name, locked);
        end
        drain(name);
    endtask

    task automatic test_noise();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            step(16'(int'($urandom_range(400)) - 200), 1'b1);
            if (meas_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL noise: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(-16'sd1000, 1'b1);
            step(16'sd1000, 1'b1);
            push(2, 1000, -1000, 2000);
        end
        drain("back_to_back");
    endtask

    task automatic test_timeout();
        do_reset();
        chk_t = 1'b1;
        step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        tests++;
        if (locked_t !== 1'b1) begin
            fails++;
            $display("FAIL timeout_lock: locked=%b, required 1", locked_t);
        end
        for (int k = 1; k <= 15; k++) begin
            step(16'sd1000, 1'b1);
            tests++;
            if (timeout_t !== (k == 15) || locked_t !== (k != 15)) begin
                fails++;
                $display("FAIL timeout_sample%0d: timeout=%b locked=%b, required timeout=%b locked=%b",
                         k, timeout_t, locked_t, (k == 15), (k != 15));
            end
        end
        step(16'sd1000, 1'b1);
        tests++;
        if (timeout_t !== 1'b0 || locked_t !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: timeout=%b locked=%b, required 0 0", timeout_t, locked_t);
        end
        drain("timeout");

        // Crossing exactly at the last count value must measure, not time out.
        do_reset();
        step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        for (int k = 0; k < 14; k++) step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        push_t(15, 1000, -1000, 2000);
        push(15, 1000, -1000, 2000);
        tests++;
        if (timeout_t !== 1'b0 || locked_t !== 1'b1) begin
            fails++;
            $display("FAIL period_max: timeout=%b locked=%b, required 0 1", timeout_t, locked_t);
        end
        drain("period_max");
        chk_t = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                step((i < 4) ? -16'sd1000 : 16'sd1000, 1'b1);
                if (i == 4 && c == 1) push(8, 1000, -1000, 2000);
            end
        end
        step(-16'sd1000, 1'b1);
        step(-16'sd1000, 1'b1);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_locked: locked=%b, required 1", locked);
        end
        reset = 1'b1;
        step(16'sd1000, 1'b1);
        reset = 1'b0;
        check_zero("reset_mid");
        for (int i = 0; i < 3; i++) step(16'sd1000, 1'b1);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_unarmed: locked=%b, required 0", locked);
        end
        for (int i = 0; i < 4; i++) step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        tests++;
        if (locked !== 1'b1 || meas_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_relock: locked=%b meas_valid=%b, required 1 0", locked, meas_valid);
        end
        for (int i = 0; i < 3; i++) step(16'sd1000, 1'b1);
        for (int i = 0; i < 4; i++) step(-16'sd1000, 1'b1);
        step(16'sd1000, 1'b1);
        push(8, 1000, -1000, 2000);
        drain("reset_mid");
    endtask

    task automatic test_triangle();
        logic signed [15:0] tri_v[32];
        for (int k = 0; k < 16; k++) tri_v[k] = 16'(-32768 + 4096 * k);
        tri_v[16] = 16'sd32767;
        for (int k = 0; k < 15; k++) tri_v[17 + k] = 16'(28672 - 4096 * k);
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 32; k++) begin
                step(tri_v[k], 1'b1);
                if (p >= 1 && k == 9) push(32, 32767, -32768, 65535);
            end
        end
        drain("triangle");
    endtask

    initial begin
        reset        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        test_reset();
        test_square(1'b0, "square");
        test_noise();
        test_square(1'b1, "square_gaps");
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_triangle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
Receive-side companion to the sine generator and low-pass filter chain. Consumes a stream of signed samples and locks onto rising zero crossings, using hysteresis to reject noise. For each full cycle of the waveform it reports the period in samples, the minimum, the maximum and the peak-to-peak amplitude. The bench uses it to check generator and filter output automatically; the datapath uses it for signal monitoring.

Parameters:
DATA_W, 16, sample width; samples are signed two's complement.
CNT_W, 20, period counter width; also sets the timeout limit of 2^CNT_W-1 samples.
HYST, 256, hysteresis threshold; positive, must be less than 2^(DATA_W-1).

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
sample_in  in  DATA_W  signed input sample.
sample_valid  in  1  sample_in is consumed on any clk edge where this is high.
meas_valid  out  1  one-cycle pulse; the measurement outputs below are updated on this cycle.
period_out  out  CNT_W  samples between two consecutive qualified rising crossings.
max_out  out  DATA_W  signed maximum sample over the measured period.
min_out  out  DATA_W  signed minimum sample over the measured period.
amp_out  out  DATA_W+1  unsigned value of max_out minus min_out.
locked  out  1  high while in the MEASURE state.
timeout  out  1  one-cycle pulse when lock is lost because no crossing arrived in time.

Behaviour:
- Definitions:
  - "low" means the sample is less than or equal to -HYST (signed compare).
  - "high" means the sample is greater than or equal to +HYST.
  - "armed" is an internal flag. It is set by a low sample and cleared at each qualified crossing.
  - A qualified rising crossing is a valid high sample while armed is 1.
- Samples with sample_valid=0 are ignored. All state, counters and outputs hold; gaps do not count toward the period.
- Reset, synchronous, takes effect on the next edge, including mid-measurement:
  - state becomes IDLE, armed becomes 0 and the counter becomes 0.
  - meas_valid, timeout and locked become 0.
  - period_out, max_out, min_out and amp_out become 0.
  - No partial measurement is emitted.
- State IDLE: a low sample sets armed. A qualified crossing moves to MEASURE and:
  - sets cnt=0 and clears armed;
  - seeds run_max and run_min with the crossing sample.
- State MEASURE, for each valid sample that is not a qualified crossing:
  - cnt is incremented;
  - run_max and run_min are updated;
  - a low sample sets armed.
- State MEASURE, on a qualified crossing:
  - period_out = cnt+1;
  - max_out and min_out take the current run_max and run_min, excluding the crossing sample;
  - amp_out = run_max - run_min, computed at DATA_W+1 bits with no overflow;
  - meas_valid pulses high for one cycle;
  - the crossing sample reseeds run_max and run_min, cnt resets to 0 and armed is cleared.
- Latency: outputs are registered. meas_valid is high on the cycle after the edge on which the crossing sample is accepted.
- Timeout: in MEASURE, a valid non-crossing sample with cnt = 2^CNT_W-2 causes:
  - a one-cycle timeout pulse;
  - a return to IDLE with armed cleared;
  - no meas_valid.
  - A qualified crossing on that same sample takes priority: it is a normal measurement with period 2^CNT_W-1.
- A single sample that is both low and high is impossible because HYST>0.
- A sample inside (-HYST, +HYST) never changes armed.
- meas_valid and timeout are never high on the same cycle.
- Back-to-back crossings: the minimum period is 2, since arming needs at least one low sample. A period of 1 is impossible.

Decomposition:
- Package waveform_pkg holds:
  - the state enum, IDLE and MEASURE;
  - default constants DATA_W=16, CNT_W=20 and HYST=256.
- One sub-module, minmax_tracker (parameter DATA_W), with ports clk, seed, seed_val, update, din, max, min. It is the running signed min/max register pair; seed overrides update.
- Crossing detection, the FSM and the counter stay in the top module.

Test Plan:
- Square wave, -1000 x4 then +1000 x4, repeated with sample_valid=1 always. The first pulse comes after the second rising crossing. Expected: period_out=8, max_out=1000, min_out=-1000, amp_out=2000, then one pulse every 8 samples.
- Noise around zero in [-200, +200] for 500 samples, with defaults. Expected: no meas_valid, locked=0, timeout=0.
- Same square wave with sample_valid toggling 1,0 every cycle. Expected: period_out=8 still, with a pulse every 16 clk cycles.
- Bench with CNT_W=4. Lock, then hold +1000 constant. Expected: timeout pulses once on the cycle after the 15th post-crossing sample (cnt reaches 14), then locked=0 and meas_valid is never asserted.
- Assert reset for one cycle mid-period while locked. Expected: all outputs 0 on the next cycle. Re-locking requires a low sample and then a high sample, and the first measurement comes a full period later.
- Triangle ramp -32768 to 32767 and back in steps of 4096. Expected: amp_out=65535 with no wrap, and period_out equal to the ramp length.
